// File: rtl/bitreversal_reg_driver_pkg.sv
// Shared types and register map for the bit-reversal register driver.
package bitreversal_reg_driver_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    typedef enum logic [3:0] {
        StIdle,
        StWrDin,
        StWrStart,
        StPoll,
        StClrStart,
        StSetRead,
        StRdDout,
        StClrRead,
        StClrDone,
        StOut
    } state_e;

    localparam logic [31:0] REG_DIN   = 32'h00;
    localparam logic [31:0] REG_START = 32'h04;
    localparam logic [31:0] REG_READ  = 32'h08;
    localparam logic [31:0] REG_DONE  = 32'h0C;
    localparam logic [31:0] REG_DOUT  = 32'h10;

    localparam int unsigned DONE_BIT = 0;

endpackage

// File: rtl/bitreversal_reg_xfer.sv
// Single register-bus transaction engine: launches on go, holds fields until ready,
// then drops valid for at least one cycle before the next launch.
module bitreversal_reg_xfer
    import bitreversal_reg_driver_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        go_i,
    input  logic [31:0] addr_i,
    input  logic        write_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        error_o,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i
);

    reg_req_t req_q, req_d;
    logic     accept;
    logic     launch;

    assign accept = req_q.valid & reg_rsp_i.ready;
    // Launch is blocked while valid is high, so the accept cycle is always followed by an idle one.
    assign launch = go_i & ~req_q.valid;

    always_comb begin
        req_d = req_q;
        if (accept) begin
            req_d.valid = 1'b0;
        end else if (launch) begin
            req_d.addr  = addr_i;
            req_d.write = write_i;
            req_d.wdata = wdata_i;
            req_d.wstrb = 4'hF;
            req_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign reg_req_o = req_q;
    assign done_o    = accept;
    assign rdata_o   = accept ? reg_rsp_i.rdata : '0;
    assign error_o   = accept & reg_rsp_i.error;

endmodule

// File: rtl/bitreversal_reg_driver.sv
// Stream-to-register initiator running one bit-reversal job per input word.
// Optional DONE-poll timeout is enabled by defining BITREV_DRV_TIMEOUT_EN.
module bitreversal_reg_driver
    import bitreversal_reg_driver_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned POLL_GAP     = 4,
    parameter int unsigned POLL_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        out_err_o,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic        busy_o
);

    state_e      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] gap_q, gap_d;

    logic        go;
    logic [31:0] offs;
    logic        write;
    logic [31:0] wdata;
    logic        xfer_done;
    logic        xfer_err;
    logic [31:0] xfer_rdata;
    logic        poll_expired;

`ifdef BITREV_DRV_TIMEOUT_EN
    logic [31:0] polls_q, polls_d;

    assign poll_expired = (polls_q + 32'd1) >= POLL_TIMEOUT;
`else
    logic unused_timeout;

    assign unused_timeout = ^POLL_TIMEOUT;
    assign poll_expired   = 1'b0;
`endif

    bitreversal_reg_xfer u_xfer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .go_i      (go),
        .addr_i    (BASE_ADDR + offs),
        .write_i   (write),
        .wdata_i   (wdata),
        .done_o    (xfer_done),
        .rdata_o   (xfer_rdata),
        .error_o   (xfer_err),
        .reg_req_o (reg_req_o),
        .reg_rsp_i (reg_rsp_i)
    );

    // Per-state bus request.
    always_comb begin
        go    = 1'b0;
        offs  = REG_DIN;
        write = 1'b1;
        wdata = '0;
        case (state_q)
            StWrDin:    begin go = 1'b1; offs = REG_DIN;   wdata = data_q; end
            StWrStart:  begin go = 1'b1; offs = REG_START; wdata = 32'd1;  end
            StPoll:     begin go = (gap_q <= 32'd1); offs = REG_DONE; write = 1'b0; end
            StClrStart: begin go = 1'b1; offs = REG_START; wdata = 32'd0;  end
            StSetRead:  begin go = 1'b1; offs = REG_READ;  wdata = 32'd1;  end
            StRdDout:   begin go = 1'b1; offs = REG_DOUT;  write = 1'b0;   end
            StClrRead:  begin go = 1'b1; offs = REG_READ;  wdata = 32'd0;  end
            StClrDone:  begin go = 1'b1; offs = REG_DONE;  wdata = 32'd1 << DONE_BIT; end
            default:    ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        gap_d   = (gap_q != 32'd0) ? gap_q - 32'd1 : 32'd0;
`ifdef BITREV_DRV_TIMEOUT_EN
        polls_d = polls_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    data_d  = in_data_i;
                    err_d   = 1'b0;
                    state_d = StWrDin;
`ifdef BITREV_DRV_TIMEOUT_EN
                    polls_d = '0;
`endif
                end
            end
            StWrDin:   if (xfer_done) state_d = xfer_err ? StClrStart : StWrStart;
            StWrStart: if (xfer_done) state_d = xfer_err ? StClrStart : StPoll;
            StPoll: begin
                if (xfer_done) begin
`ifdef BITREV_DRV_TIMEOUT_EN
                    polls_d = polls_q + 32'd1;
`endif
                    if (xfer_err || xfer_rdata[DONE_BIT]) begin
                        state_d = StClrStart;
                    end else if (poll_expired) begin
                        err_d   = 1'b1;
                        state_d = StClrStart;
                    end else begin
                        gap_d = POLL_GAP;
                    end
                end
            end
            StClrStart: if (xfer_done) state_d = StSetRead;
            StSetRead:  if (xfer_done) state_d = StRdDout;
            StRdDout: begin
                if (xfer_done) begin
                    if (!xfer_err) data_d = xfer_rdata;
                    state_d = StClrRead;
                end
            end
            StClrRead: if (xfer_done) state_d = StClrDone;
            StClrDone: if (xfer_done) state_d = StOut;
            StOut:     if (out_ready_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // Errors once in cleanup only mark the job; the flow continues regardless.
        if (xfer_err) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            data_q  <= '0;
            err_q   <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
        end
    end

`ifdef BITREV_DRV_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            polls_q <= '0;
        end else begin
            polls_q <= polls_d;
        end
    end
`endif

    assign in_ready_o  = (state_q == StIdle) & ~rst_i;
    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = (state_q == StOut);
    assign out_err_o   = (state_q == StOut) & err_q;
    assign out_data_o  = ((state_q == StOut) && !err_q) ? data_q : '0;

endmodule

// File: tb/tb_bitreversal_reg_driver.sv
// Randomised scoreboard bench for bitreversal_reg_driver with a behavioural accelerator slave.
module tb_bitreversal_reg_driver;
    import bitreversal_reg_driver_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0100;
    localparam int unsigned TMO  = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_err;
    reg_req_t    req;
    reg_rsp_t    rsp = '0;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    bus_t exp_bus[$];
    res_t exp_out[$];

    // Stimulus-owned slave configuration
    int          job_id = 0;
    int          cfg_done_after = 0;
    logic        cfg_zero_wait = 1'b0;
    logic [31:0] cfg_err_addr = '0;
    int          stale_req = 0;

    always #5 clk = ~clk;

    bitreversal_reg_driver #(
        .BASE_ADDR    (BASE),
        .POLL_GAP     (0),
        .POLL_TIMEOUT (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_err_o   (out_err),
        .reg_req_o   (req),
        .reg_rsp_i   (rsp),
        .busy_o      (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[31-i] = v[i];
        return r;
    endfunction

    // Behavioural accelerator slave plus bus scoreboard
    logic [31:0] s_din = '0;
    logic        s_started = 1'b0;
    logic        s_done_flag = 1'b0;
    int          s_polls = 0;
    int          stale_seen = 0;
    int          err_job = 0;
    int          wait_left = 0;
    logic        in_txn = 1'b0;
    bus_t        eb;

    always @(negedge clk) begin
        rsp = '0;
        if (rst) begin
            in_txn = 1'b0;
        end else begin
            if (stale_req != stale_seen) begin
                stale_seen  = stale_req;
                s_done_flag = 1'b1;
            end
            if (req.valid) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    wait_left = cfg_zero_wait ? 0 : int'($urandom_range(0, 2));
                end
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    in_txn = 1'b0;
                    if (exp_bus.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL bus_unexpected: got addr %0h, want no transaction", req.addr);
                    end else begin
                        eb = exp_bus.pop_front();
                        check("bus_txn",
                              128'({req.addr, req.write, (req.write ? req.wdata : 32'h0), req.wstrb}),
                              128'({eb.addr, eb.write, eb.wdata, 4'hF}));
                    end
                    rsp.ready = 1'b1;
                    if (req.addr == cfg_err_addr && err_job != job_id) begin
                        err_job   = job_id;
                        rsp.error = 1'b1;
                    end else if (req.write) begin
                        case (req.addr - BASE)
                            32'h00: s_din = req.wdata;
                            32'h04: if (req.wdata[0]) begin s_started = 1'b1; s_polls = 0; end
                            32'h0C: if (req.wdata[0]) begin
                                s_done_flag = 1'b0;
                                s_started   = 1'b0;
                                s_polls     = 0;
                            end
                            default: ;
                        endcase
                    end else begin
                        case (req.addr - BASE)
                            32'h0C: begin
                                rsp.rdata = {31'b0, s_done_flag || (s_started && s_polls >= cfg_done_after)};
                                s_polls++;
                            end
                            32'h10: rsp.rdata = bitrev(s_din);
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Output monitor
    logic        stalled = 1'b0;
    logic [32:0] stall_prev = '0;
    res_t        eo;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (stalled) begin
                check("out_hold", 128'({out_err, out_data}), 128'(stall_prev));
                check("in_ready_during_out", 128'(in_ready), 128'(0));
            end
            if (out_ready) begin
                stalled = 1'b0;
                if (exp_out.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_unexpected: got %0h, want no output", out_data);
                end else begin
                    eo = exp_out.pop_front();
                    check("out_result", 128'({out_err, out_data}), 128'({eo.err, eo.data}));
                end
            end else begin
                stalled    = 1'b1;
                stall_prev = {out_err, out_data};
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic push_w(input logic [31:0] off, input logic [31:0] d);
        bus_t b;
        b.addr = BASE + off; b.write = 1'b1; b.wdata = d;
        exp_bus.push_back(b);
    endtask

    task automatic push_r(input logic [31:0] off);
        bus_t b;
        b.addr = BASE + off; b.write = 1'b0; b.wdata = '0;
        exp_bus.push_back(b);
    endtask

    // err_kind: 0 none, 1 error on DIN, 2 error on START, 3 error on DOUT
    task automatic expect_job(input logic [31:0] data, input int done_after, input int err_kind,
                              input bit stale);
        res_t r;
        bit   err;
        int   reads;
        err = 1'b0;
        push_w(32'h00, data);
        if (err_kind == 1) err = 1'b1;
        if (!err) begin
            push_w(32'h04, 32'd1);
            if (err_kind == 2) err = 1'b1;
        end
        if (!err) begin
            if (stale) reads = 1;
            else reads = done_after + 1;
`ifdef BITREV_DRV_TIMEOUT_EN
            if (reads > int'(TMO)) begin
                reads = TMO;
                err   = 1'b1;
            end
`endif
            for (int i = 0; i < reads; i++) push_r(32'h0C);
        end
        push_w(32'h04, 32'd0);
        push_w(32'h08, 32'd1);
        push_r(32'h10);
        push_w(32'h08, 32'd0);
        push_w(32'h0C, 32'd1);
        if (err_kind == 3) err = 1'b1;
        r.err  = err;
        r.data = err ? 32'h0 : bitrev(data);
        exp_out.push_back(r);
    endtask

    task automatic setup_job(input int done_after, input int err_kind, input bit stale,
                             input bit zw);
        job_id++;
        cfg_done_after = done_after;
        cfg_zero_wait  = zw;
        case (err_kind)
            1:       cfg_err_addr = BASE + 32'h00;
            2:       cfg_err_addr = BASE + 32'h04;
            3:       cfg_err_addr = BASE + 32'h10;
            default: cfg_err_addr = '0;
        endcase
        if (stale) stale_req++;
    endtask

    task automatic accept_input(input logic [31:0] data);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = data;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                n_bad++;
                $display("FAIL accept_timeout: got in_ready 0, want 1");
                finish_run();
            end
        end
        @(posedge clk);
    endtask

    task automatic run_job(input logic [31:0] data, input int done_after, input int err_kind,
                           input bit stale, input bit zw, input int hold, input bit lat);
        int   edges;
        logic busy_ok;
        logic rdy_ok;
        setup_job(done_after, err_kind, stale, zw);
        expect_job(data, done_after, err_kind, stale);
        out_ready = (hold == 0);
        accept_input(data);
        edges   = 1;
        busy_ok = 1'b1;
        rdy_ok  = 1'b1;
        forever begin
            #1;
            // Junk words offered while busy must be ignored.
            in_valid = (edges <= 6);
            in_data  = data ^ 32'hDEAD_BEEF;
            if (out_valid) break;
            if (!busy) busy_ok = 1'b0;
            if (in_ready) rdy_ok = 1'b0;
            if (edges > 3000) begin
                n_bad++;
                $display("FAIL job_timeout: got no out_valid, want one");
                finish_run();
            end
            @(posedge clk);
            edges++;
        end
        in_valid = 1'b0;
        check("busy_during_job", 128'(busy_ok), 128'(1));
        check("in_ready_low_while_busy", 128'(rdy_ok), 128'(1));
        if (lat) check("latency_edges", 128'(edges), 128'(17));
        repeat (hold) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_out", 128'({in_ready, out_valid}), 128'({1'b1, 1'b0}));
    endtask

    task automatic reset_mid_poll();
        int n;
        setup_job(3, 0, 1'b0, 1'b0);
        expect_job(32'h0F0F_1234, 3, 0, 1'b0);
        accept_input(32'h0F0F_1234);
        #1 in_valid = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (req.valid && !req.write && req.addr == BASE + 32'h0C) break;
            n++;
            if (n > 500) begin
                n_bad++;
                $display("FAIL poll_wait_timeout: got no DONE read, want one");
                finish_run();
            end
        end
        #1 rst = 1'b1;
        #1;
        check("rst_req_valid", 128'(req.valid), 128'(0));
        check("rst_busy", 128'({busy, out_valid}), 128'(0));
        @(negedge clk);
        exp_bus.delete();
        exp_out.delete();
        #2 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 128'({in_ready, busy}), 128'({1'b1, 1'b0}));
    endtask

    initial begin
        int ek;
        int r;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", 128'(req), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_err", 128'(out_err), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_busy_init", 128'(busy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        #2 rst = 1'b0;
        @(negedge clk);

        run_job(32'h0000_0001, 2, 0, 1'b0, 1'b0, 0, 1'b0);
        run_job($urandom, 0, 0, 1'b0, 1'b1, 0, 1'b1);
        run_job(32'h1234_5678, 1, 2, 1'b0, 1'b0, 0, 1'b0);
        run_job(32'hA5A5_0F0F, 1, 0, 1'b0, 1'b0, 10, 1'b0);
        run_job(32'h0000_00FF, 50, 0, 1'b1, 1'b0, 0, 1'b0);
        run_job(32'hCAFE_0001, 0, 1, 1'b0, 1'b0, 0, 1'b0);
        run_job(32'h8000_0003, 2, 3, 1'b0, 1'b0, 2, 1'b0);
`ifdef BITREV_DRV_TIMEOUT_EN
        run_job(32'h0000_00AA, 1000, 0, 1'b0, 1'b0, 0, 1'b0);
`endif
        reset_mid_poll();
        run_job(32'h0001_0000, 1, 0, 1'b0, 1'b0, 0, 1'b0);

        for (int j = 0; j < 24; j++) begin
            r  = int'($urandom_range(0, 9));
            ek = (r < 3) ? r + 1 : 0;
            run_job($urandom, int'($urandom_range(0, 3)), ek, ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (4) @(posedge clk);
        check("bus_queue_empty", 128'(exp_bus.size()), 128'(0));
        check("out_queue_empty", 128'(exp_out.size()), 128'(0));
        finish_run();
    end

endmodule
